// File: rtl/svcoeff_pkg.sv
// Shared types and sizing helpers for the slidevm coefficient scheduler.
package svcoeff_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReady,
        StStream,
        StHold
    } state_e;

    localparam int unsigned ErrNoBank  = 0;
    localparam int unsigned ErrOverrun = 1;
    localparam int unsigned ErrShort   = 2;

    function automatic int unsigned calc_ncoeff(input int unsigned blocksize,
                                                input int unsigned wincols,
                                                input int unsigned winrows);
        return blocksize * wincols * winrows;
    endfunction

    // One extra bit so the pointer can rest at NCOEFF once a frame is exhausted.
    function automatic int unsigned calc_ptr_width(input int unsigned ncoeff);
        return $clog2(ncoeff) + 1;
    endfunction

endpackage

// File: rtl/svcoeff_bank_ram.sv
// Two-bank coefficient store: one write port, one registered read port.
// A same-address write wins over the stored word so a freshly swapped bank reads new data.
module svcoeff_bank_ram #(
    parameter int unsigned CWIDTH = 9,
    parameter int unsigned DEPTH  = 2048,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic signed [CWIDTH-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [CWIDTH-1:0] rd_data
);

    logic signed [CWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/svcoeff_sched.sv
// Double-buffered SVM coefficient scheduler: streams the active bank into slidevm,
// swaps banks only between frames and flags sequencing faults.
module svcoeff_sched
    import svcoeff_pkg::*;
#(
    parameter int unsigned CWIDTH    = 9,
    parameter int unsigned BLOCKSIZE = 8,
    parameter int unsigned WINCOLS   = 8,
    parameter int unsigned WINROWS   = 16,
    parameter int unsigned WPI       = 4,
    localparam int unsigned NCOEFF   = calc_ncoeff(BLOCKSIZE, WINCOLS, WINROWS),
    localparam int unsigned AW       = $clog2(NCOEFF),
    localparam int unsigned PW       = calc_ptr_width(NCOEFF),
    localparam int unsigned WCW      = $clog2(WPI)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_wr,
    input  logic [AW-1:0]            cfg_addr,
    input  logic signed [CWIDTH-1:0] cfg_data,
    input  logic                     cfg_commit,
    input  logic                     in_fv,
    input  logic                     dvi,
    input  logic [WCW-1:0]           wincount,
    output logic signed [CWIDTH-1:0] svcoeff_out,
    output logic [PW-1:0]            coeff_ptr,
    output logic                     ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic [2:0]               err,
    input  logic                     err_clr
);

    state_e        state_q, state_d;
    logic          bank_q, bank_d;
    logic          bank_valid_q, bank_valid_d;
    logic          swap_pend_q, swap_pend_d;
    logic          start_q, start_d;
    logic          fv_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [2:0]    err_q, err_d, err_set;
    logic          frame_done_q, frame_done_d;
    logic          fv_rise, fv_fall, px_hit, do_swap, rd_en;

    assign fv_rise = in_fv & ~fv_q;
    assign fv_fall = ~in_fv & fv_q;
    assign px_hit  = dvi && (wincount == '0);

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        bank_valid_d = bank_valid_q;
        swap_pend_d  = swap_pend_q | cfg_commit;
        start_d      = 1'b0;
        ptr_d        = ptr_q;
        err_set      = '0;
        frame_done_d = 1'b0;
        do_swap      = swap_pend_q && ((state_q == StIdle) || (state_q == StReady));

        if (do_swap) begin
            bank_d       = ~bank_q;
            bank_valid_d = 1'b1;
            swap_pend_d  = cfg_commit;
            ptr_d        = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (do_swap) begin
                    state_d = StReady;
                    start_d = fv_rise;
                end else if (fv_rise && !bank_valid_q) begin
                    err_set[ErrNoBank] = 1'b1;
                end
            end
            StReady: begin
                // A frame start that collides with a swap is replayed next cycle.
                if (do_swap) begin
                    start_d = fv_rise | start_q;
                end else if (fv_rise || start_q) begin
                    state_d = StStream;
                    ptr_d   = '0;
                end
            end
            StStream: begin
                if (fv_fall) begin
                    err_set[ErrShort] = 1'b1;
                    state_d           = StReady;
                    ptr_d             = '0;
                end else if (px_hit) begin
                    ptr_d = ptr_q + PW'(1);
                    if (ptr_q == PW'(NCOEFF - 1)) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (px_hit) begin
                    err_set[ErrOverrun] = 1'b1;
                end
                if (fv_fall) begin
                    frame_done_d = 1'b1;
                    state_d      = StReady;
                    ptr_d        = '0;
                end
            end
        endcase

        err_d = err_clr ? 3'b000 : (err_q | err_set);
        // Past the last coefficient the output register simply holds.
        rd_en = bank_valid_d && (ptr_d < PW'(NCOEFF));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            bank_q       <= 1'b0;
            bank_valid_q <= 1'b0;
            swap_pend_q  <= 1'b0;
            start_q      <= 1'b0;
            fv_q         <= 1'b0;
            ptr_q        <= '0;
            err_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            bank_valid_q <= bank_valid_d;
            swap_pend_q  <= swap_pend_d;
            start_q      <= start_d;
            fv_q         <= in_fv;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    svcoeff_bank_ram #(
        .CWIDTH(CWIDTH),
        .DEPTH (2 * NCOEFF)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (cfg_wr),
        .wr_addr({~bank_q, cfg_addr}),
        .wr_data(cfg_data),
        .rd_en  (rd_en),
        .rd_addr({bank_d, ptr_d[AW-1:0]}),
        .rd_data(svcoeff_out)
    );

    assign coeff_ptr  = ptr_q;
    assign ready      = bank_valid_q && (state_q == StReady);
    assign busy       = (state_q == StStream) || (state_q == StHold);
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_svcoeff_sched.sv
// Directed bench for svcoeff_sched: table-driven pixel steps plus multi-frame sequences.
module tb_svcoeff_sched;

    localparam int NC = 1024;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cfg_wr;
    logic [9:0]        cfg_addr;
    logic signed [8:0] cfg_data;
    logic              cfg_commit;
    logic              in_fv;
    logic              dvi;
    logic [1:0]        wincount;
    logic signed [8:0] svcoeff_out;
    logic [10:0]       coeff_ptr;
    logic              ready;
    logic              busy;
    logic              frame_done;
    logic [2:0]        err;
    logic              err_clr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       dvi;
        logic [1:0] wc;
        int         ptr;
    } vec_t;

    vec_t vecs [8];

    svcoeff_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .in_fv      (in_fv),
        .dvi        (dvi),
        .wincount   (wincount),
        .svcoeff_out(svcoeff_out),
        .coeff_ptr  (coeff_ptr),
        .ready      (ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic signed [8:0] coef_a(input int k);
        logic [31:0] v;
        v = k - 512;
        return v[8:0];
    endfunction

    function automatic logic signed [8:0] coef_b(input int k);
        logic [31:0] v;
        v = k * 37 + 11;
        return v[8:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int k;
        int cyc;

        vecs[0] = '{1'b1, 2'd0, 1};
        vecs[1] = '{1'b1, 2'd1, 1};
        vecs[2] = '{1'b0, 2'd0, 1};
        vecs[3] = '{1'b1, 2'd0, 2};
        vecs[4] = '{1'b1, 2'd3, 2};
        vecs[5] = '{1'b1, 2'd2, 2};
        vecs[6] = '{1'b1, 2'd0, 3};
        vecs[7] = '{1'b0, 2'd1, 3};

        reset_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        in_fv = 1'b0; dvi = 1'b0; wincount = '0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_out", svcoeff_out, 0);
        chk("rst_ptr", coeff_ptr, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        // Frame with no bank loaded.
        in_fv = 1'b1; tick(); tick();
        chk("nobank_err", err, 1);
        chk("nobank_busy", busy, 0);
        chk("nobank_out", svcoeff_out, 0);
        chk("nobank_ready", ready, 0);
        in_fv = 1'b0; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        chk("nobank_clr", err, 0);

        // Load bank A and commit.
        for (int i = 0; i < NC; i++) begin
            cfg_wr = 1'b1; cfg_addr = 10'(i); cfg_data = coef_a(i); tick();
        end
        cfg_wr = 1'b0; cfg_commit = 1'b1; tick();
        cfg_commit = 1'b0;
        chk("commit_ready_wait", ready, 0);
        tick();
        chk("swap_ready", ready, 1);
        chk("swap_ptr", coeff_ptr, 0);
        chk("swap_out", svcoeff_out, coef_a(0));

        // Frame 1: table steps, then random dvi with wincount cycling.
        in_fv = 1'b1; tick();
        chk("f1_busy", busy, 1);
        chk("f1_out0", svcoeff_out, coef_a(0));
        for (int i = 0; i < 8; i++) begin
            dvi = vecs[i].dvi; wincount = vecs[i].wc; tick();
            chk("vec_ptr", coeff_ptr, vecs[i].ptr);
            chk("vec_out", svcoeff_out, coef_a(vecs[i].ptr));
        end
        k = 3; cyc = 0;
        while (k < NC && cyc < 20000) begin
            dvi = 1'($urandom_range(0, 1)); wincount = 2'(cyc); tick();
            if (dvi && wincount == 2'd0) k++;
            chk("rnd_ptr", coeff_ptr, k);
            chk("rnd_out", svcoeff_out, coef_a(k < NC ? k : NC - 1));
            cyc++;
        end
        dvi = 1'b0; tick();
        chk("f1_hold_busy", busy, 1);
        chk("f1_hold_out", svcoeff_out, coef_a(NC - 1));
        in_fv = 1'b0; tick();
        chk("f1_done", frame_done, 1);
        chk("f1_busy_end", busy, 0);
        tick();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_ready", ready, 1);
        chk("f1_err", err, 0);

        // Frame 2: fill bank B while streaming A, overrun by 6 pixels, commit in HOLD.
        in_fv = 1'b1; tick();
        for (int i = 0; i < NC + 6; i++) begin
            dvi = 1'b1; wincount = 2'd0;
            cfg_wr = (i < NC); cfg_addr = 10'(i); cfg_data = coef_b(i);
            tick();
            k = (i + 1 < NC) ? i + 1 : NC;
            chk("f2_ptr", coeff_ptr, k);
            chk("f2_out", svcoeff_out, coef_a(k < NC ? k : NC - 1));
        end
        cfg_wr = 1'b0; dvi = 1'b0; cfg_commit = 1'b1; tick();
        cfg_commit = 1'b0;
        chk("ovr_err", err, 2);
        chk("ovr_ptr", coeff_ptr, NC);
        chk("ovr_busy", busy, 1);
        chk("ovr_out", svcoeff_out, coef_a(NC - 1));
        in_fv = 1'b0; tick();
        chk("f2_done", frame_done, 1);
        chk("f2_noswap_out", svcoeff_out, coef_a(0));
        tick();
        chk("f2_swap_out", svcoeff_out, coef_b(0));
        chk("f2_ready", ready, 1);
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        chk("f2_clr", err, 0);

        // Frame 3: short frame on bank B.
        in_fv = 1'b1; tick();
        chk("f3_out0", svcoeff_out, coef_b(0));
        for (int i = 0; i < 500; i++) begin
            dvi = 1'b1; wincount = 2'd0; tick();
        end
        dvi = 1'b0;
        chk("f3_ptr", coeff_ptr, 500);
        chk("f3_out", svcoeff_out, coef_b(500));
        in_fv = 1'b0; tick();
        chk("short_err", err, 4);
        chk("short_ready", ready, 1);
        chk("short_busy", busy, 0);
        chk("short_ptr", coeff_ptr, 0);
        chk("short_out", svcoeff_out, coef_b(0));
        chk("short_nodone", frame_done, 0);
        err_clr = 1'b1; tick();
        err_clr = 1'b0;

        // Frame 4: restarts at coeff 0, then reset at consume 300.
        in_fv = 1'b1; tick();
        chk("f4_busy", busy, 1);
        chk("f4_out0", svcoeff_out, coef_b(0));
        dvi = 1'b1; tick();
        chk("f4_ptr1", coeff_ptr, 1);
        chk("f4_out1", svcoeff_out, coef_b(1));
        for (int i = 1; i < 300; i++) tick();
        dvi = 1'b0;
        chk("f4_ptr300", coeff_ptr, 300);
        reset_n = 1'b0; in_fv = 1'b0; #1;
        chk("mrst_out", svcoeff_out, 0);
        chk("mrst_ptr", coeff_ptr, 0);
        chk("mrst_ready", ready, 0);
        chk("mrst_busy", busy, 0);
        tick();
        reset_n = 1'b1; tick();
        chk("post_ready", ready, 0);
        chk("post_out", svcoeff_out, 0);
        in_fv = 1'b1; tick();
        chk("post_nobank", err, 1);
        err_clr = 1'b1; cfg_commit = 1'b1; tick();
        err_clr = 1'b0; cfg_commit = 1'b0;
        chk("clr_commit_err", err, 0);
        tick();
        chk("recommit_ready", ready, 1);
        chk("recommit_ptr", coeff_ptr, 0);
        in_fv = 1'b0; tick();
        in_fv = 1'b1; tick();
        dvi = 1'b1; tick();
        dvi = 1'b0;
        // Bank select toggled back to the untouched A bank.
        chk("recommit_out1", svcoeff_out, coef_a(1));
        in_fv = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svcoeff_sched.md
Name: svcoeff_sched

Overview:
- Coefficient scheduler and configurator for the slidevm sliding-window SVM datapath.
- Holds two banks of signed SVM coefficients. The host fills the shadow bank through a write port; the scheduler streams the active bank into slidevm's svcoeff_in.
- Coefficient k is presented on the k-th accepted pixel with wincount==0.
- Bank swaps happen only between frames. Sequencing faults are flagged.

Parameters:
- CWIDTH, 9, signed coefficient width.
- BLOCKSIZE, 8, pixels per block column.
- WINCOLS, 8, blocks per window row.
- WINROWS, 16, window rows.
- WPI, 4, windows per image row; must be >= 2.
- NCOEFF, BLOCKSIZE*WINCOLS*WINROWS (localparam, 1024 by default), coefficients per bank.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_wr  in  1  write strobe into the shadow bank.
- cfg_addr  in  $clog2(NCOEFF)  write address.
- cfg_data  in  CWIDTH  signed coefficient.
- cfg_commit  in  1  marks the shadow bank complete; requests a swap.
- in_fv  in  1  frame valid, same signal that drives slidevm.
- dvi  in  1  pixel valid, same signal that drives slidevm.
- wincount  in  $clog2(WPI)  window index from slidevm.
- svcoeff_out  out  CWIDTH  signed coefficient, drives slidevm.svcoeff_in.
- coeff_ptr  out  $clog2(NCOEFF)+1  index of the coefficient currently presented.
- ready  out  1  a valid active bank exists and state is READY.
- busy  out  1  state is STREAM or HOLD.
- frame_done  out  1  one-cycle pulse when a frame completes cleanly.
- err  out  3  sticky flags: [0] nobank, [1] overrun, [2] short.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: svcoeff_out=0, coeff_ptr=0, ready=0, busy=0, frame_done=0, err=0, state=IDLE, active bank=0, bank_valid=0, swap_pending=0. RAM contents are not reset.
- Consume event: dvi && wincount==0 && state==STREAM.
- svcoeff_out is registered and always equals active[coeff_ptr], with no bubble. On a consume event it loads active[coeff_ptr+1] (prefetch) and coeff_ptr increments.
- Shadow writes (cfg_wr) are accepted in every state and never disturb the active bank. A write to the bank being swapped in, in the same cycle as the swap, lands before the swap.
- cfg_commit sets swap_pending. A commit while already pending is harmless.
- Swap occurs in the first cycle where state is IDLE or READY and swap_pending=1:
  - toggle the active bank, set bank_valid=1, clear swap_pending, coeff_ptr=0;
  - svcoeff_out is valid on the next cycle.
- State transitions:
  - IDLE: on swap, go to READY. On in_fv rising with bank_valid=0, set err[0] and stay in IDLE; svcoeff_out holds 0.
  - READY: on in_fv rising edge, go to STREAM with coeff_ptr=0.
  - If a swap and the in_fv rise fall in the same cycle, the swap is applied first. STREAM entry is delayed one cycle, and that frame's first coefficient is from the new bank.
  - STREAM: when coeff_ptr reaches NCOEFF after a consume, go to HOLD; svcoeff_out holds the last value. If in_fv falls before that, set err[2] and go to READY.
  - HOLD: a consume-qualified pixel (dvi && wincount==0) sets err[1] and the pointer does not move. On in_fv fall, pulse frame_done and go to READY.
- Pixels with wincount!=0 never move the pointer.
- err_clr has priority over a same-cycle error set.
- Asserting reset_n mid-frame returns to IDLE with bank_valid=0; the host must recommit.

Decomposition:
- Package svcoeff_pkg holds:
  - state enum: IDLE, READY, STREAM, HOLD;
  - err bit indices;
  - a function computing NCOEFF and the pointer width.
- Sub-module svcoeff_bank_ram: 2*NCOEFF x CWIDTH, one write port and one registered read port, with bank select as the address MSB.

Test Plan:
1. Write coeff[i]=i-512 (mod the CWIDTH signed range) to all 1024 addresses, commit, then run a frame with random dvi and wincount cycling 0..3. Expect svcoeff_out equal to coeff[k] at the k-th consume, frame_done one cycle after in_fv falls, and err=0.
2. Commit bank B while a frame streams bank A. Expect the frame to finish on A, the swap at the start of READY, and the next frame to start with B[0].
3. Raise in_fv before any commit. Expect err=3'b001, busy=0, and svcoeff_out=0.
4. Issue 1030 consume-qualified pixels in one frame. Expect coeff_ptr to stop at 1024, err[1] set, and svcoeff_out to hold coeff[1023].
5. Drop in_fv after 500 consumes. Expect err[2] set, state READY, and the next frame restarting at coeff[0].
6. Pulse reset_n low at consume 300. Expect all outputs at their reset values and ready=0 until a recommit; then assert err_clr and cfg_commit together and expect err=0.
